// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// default timing/depth parameters and counter reload helpers.
package uart_pkg;

   // 50 MHz clock, 115200 baud.
   localparam int unsigned CLKS_PER_BIT_DEF = 434;
   // 16-byte receive FIFO.
   localparam int unsigned DEPTH_LOG2_DEF   = 4;

   // Receiver frame states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Reload for a full bit period; counting down to 0 spans clks cycles.
   function automatic logic [15:0] bit_load(input int unsigned clks);
      return 16'(clks - 1);
   endfunction

   // Reload used after the start edge so sampling lands mid-bit.
   function automatic logic [15:0] half_bit_load(input int unsigned clks);
      return 16'((clks / 2) - 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers. A push while full is
// accepted only if a pop happens on the same edge; otherwise it is dropped and
// reported on 'dropped' for one cycle.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int unsigned WIDTH      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             dropped
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]      mem [0:DEPTH-1];
   logic [DEPTH_LOG2:0]   wr_ptr;
   logic [DEPTH_LOG2:0]   rd_ptr;
   logic                  pop_ok;
   logic                  push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

   // A pop on the same edge frees the slot the push needs, so full only blocks
   // a push when no read is accepted alongside it.
   assign pop_ok  = rd_en && !empty;
   assign push_ok = wr_en && (!full || pop_ok);
   assign dropped = wr_en && full && !pop_ok;

   // Head byte is muxed to zero while empty so stale storage never leaks out.
   assign rd_data = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

   // Pointer update; each pointer advances independently modulo 2*DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; its contents are only visible
      // through rd_data once a push has made the FIFO non-empty.
      if (push_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO. rxd is synchronized,
// frames are timed by a 16-bit down-counter and sampled mid-bit, good bytes
// are pushed into sync_fifo, bad stop bits pulse frame_err, and a byte that
// arrives with the FIFO full sets the sticky overrun flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned DEPTH_LOG2   = DEPTH_LOG2_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       uart_rdreq,
   output logic [7:0] uart_in,
   output logic       uart_empty,
   output logic       overrun,
   output logic       frame_err
);

   localparam logic [15:0] BIT_LOAD  = bit_load(CLKS_PER_BIT);
   localparam logic [15:0] HALF_LOAD = half_bit_load(CLKS_PER_BIT);

   logic       rxd_meta;
   logic       rxd_sync;
   logic       rxd_prev;
   logic       rx_fall;

   rx_state_t  state,  state_n;
   logic [15:0] cnt,   cnt_n;
   logic [2:0]  idx,   idx_n;
   logic [7:0]  shift, shift_n;
   logic        push;
   logic        bad_stop;
   logic        dropped;
   logic        fifo_full;

   // Two-flop synchronizer plus an edge-detect stage; all idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   // Only a true high-to-low transition starts a frame, so a line left low
   // after a bad frame cannot retrigger the receiver.
   assign rx_fall = rxd_prev && !rxd_sync;

   // Receiver state, bit timer, bit index and shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shift <= shift_n;
      end
   end

   // Next-state logic: count down each bit period and sample on expiry.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      shift_n  = shift;
      push     = 1'b0;
      bad_stop = 1'b0;

      unique case (state)
         IDLE: begin
            if (rx_fall) begin
               state_n = START;
               cnt_n   = HALF_LOAD;
            end
         end

         START: begin
            if (cnt == 16'd0) begin
               if (!rxd_sync) begin
                  state_n = DATA;
                  cnt_n   = BIT_LOAD;
                  idx_n   = 3'd0;
               end else begin
                  // Start bit vanished by mid-bit: treat as a glitch.
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end

         DATA: begin
            if (cnt == 16'd0) begin
               shift_n[idx] = rxd_sync;
               cnt_n        = BIT_LOAD;
               if (idx == 3'd7) state_n = STOP;
               else             idx_n   = idx + 3'd1;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end

         STOP: begin
            if (cnt == 16'd0) begin
               if (rxd_sync) push     = 1'b1;
               else          bad_stop = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign frame_err = bad_stop;

   sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (shift),
      .rd_en   (uart_rdreq),
      .rd_data (uart_in),
      .empty   (uart_empty),
      .full    (fifo_full),
      .dropped (dropped)
   );

   // Sticky overrun: set by any dropped byte, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          overrun <= 1'b0;
      else if (dropped) overrun <= 1'b1;
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with CLKS_PER_BIT=8, DEPTH_LOG2=2.
// Frames are driven bit-accurately; expected bytes go into a scoreboard queue
// as frames complete and are compared against uart_in as they are popped.
module tb_uart_rx_fifo;

   localparam int unsigned CPB   = 8;
   localparam int unsigned DL2   = 2;
   localparam int unsigned DEPTH = 1 << DL2;
   localparam int unsigned FRAME_CYCLES = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       uart_rdreq = 1'b0;
   logic [7:0] uart_in;
   logic       uart_empty;
   logic       overrun;
   logic       frame_err;

   int         n_cmp = 0;
   int         n_mis = 0;
   logic [7:0] exp_q[$];
   logic       exp_ovr = 1'b0;
   int         fe_total = 0;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DEPTH_LOG2   (DL2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .uart_rdreq (uart_rdreq),
      .uart_in    (uart_in),
      .uart_empty (uart_empty),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Count every cycle frame_err is high, sampled away from the active edge.
   always @(negedge clk) if (frame_err === 1'b1) fe_total++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one 8N1 frame starting on the next edge. Optionally raise rdreq so
   // it coincides with the stop-bit sample edge, check push latency, or assert
   // rst part way through and abandon the frame.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input bit pop_at_stop, input bit check_timing,
                             input int rst_at);
      logic [9:0] bits;
      bits = {stop_bit, data, 1'b0};
      @(posedge clk);
      for (int cyc = 0; cyc < int'(FRAME_CYCLES); cyc++) begin
         #1;
         if (rst_at >= 0 && cyc == rst_at) begin
            rst = 1'b1;
            rxd = 1'b1;
            uart_rdreq = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            exp_q.delete();
            exp_ovr = 1'b0;
            return;
         end
         if (cyc % int'(CPB) == 0) rxd = bits[cyc / int'(CPB)];
         if (pop_at_stop && cyc == 78) begin
            n_cmp++;
            if (uart_empty !== 1'b0 || exp_q.size() == 0 || uart_in !== exp_q[0]) begin
               n_mis++;
               $display("FAIL pop_at_stop_head: empty=%b uart_in=%h expected head %h",
                        uart_empty, uart_in, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
            end
            uart_rdreq = 1'b1;
         end
         if (check_timing && cyc == 78) begin
            n_cmp++;
            if (uart_empty !== 1'b1) begin
               n_mis++;
               $display("FAIL push_latency_before: uart_empty=%b expected 1", uart_empty);
            end
         end
         if (cyc == 79) begin
            uart_rdreq = 1'b0;
            if (check_timing) begin
               n_cmp++;
               if (uart_empty !== 1'b0 || uart_in !== data) begin
                  n_mis++;
                  $display("FAIL push_latency_after: empty=%b uart_in=%h expected 0/%h",
                           uart_empty, uart_in, data);
               end
            end
            if (pop_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (stop_bit) begin
               if (exp_q.size() < int'(DEPTH)) exp_q.push_back(data);
               else                            exp_ovr = 1'b1;
            end
         end
         @(posedge clk);
      end
      #1 rxd = 1'b1;
   endtask

   // Pop everything the scoreboard expects, comparing the head each time,
   // then require the FIFO to read empty.
   task automatic scoreboard_drain(input string name);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (uart_empty !== 1'b0 || uart_in !== exp_q[0]) begin
            n_mis++;
            $display("FAIL %s_head: empty=%b uart_in=%h expected 0/%h",
                     name, uart_empty, uart_in, exp_q[0]);
         end
         uart_rdreq = 1'b1;
         @(posedge clk);
         #1 uart_rdreq = 1'b0;
         void'(exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (uart_empty !== 1'b1 || uart_in !== 8'h00) begin
         n_mis++;
         $display("FAIL %s_empty: empty=%b uart_in=%h expected 1/00", name, uart_empty, uart_in);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rxd = 1'b1;
      uart_rdreq = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (uart_empty !== 1'b1 || uart_in !== 8'h00 || overrun !== 1'b0 || frame_err !== 1'b0) begin
         n_mis++;
         $display("FAIL reset_outputs: empty=%b in=%h ovr=%b fe=%b expected 1/00/0/0",
                  uart_empty, uart_in, overrun, frame_err);
      end
      rst = 1'b0;
      // rdreq while empty must not move the read pointer.
      uart_rdreq = 1'b1;
      repeat (3) @(posedge clk);
      #1 uart_rdreq = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (uart_empty !== 1'b1 || uart_in !== 8'h00 || overrun !== 1'b0) begin
         n_mis++;
         $display("FAIL rdreq_while_empty: empty=%b in=%h ovr=%b expected 1/00/0",
                  uart_empty, uart_in, overrun);
      end
   endtask

   task automatic test_single();
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
      scoreboard_drain("single");
   endtask

   task automatic test_back_to_back();
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'h02, 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'h03, 1'b1, 1'b0, 1'b0, -1);
      scoreboard_drain("b2b");
   endtask

   task automatic test_frame_err();
      int fe_start;
      fe_start = fe_total;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      repeat (6) @(posedge clk);
      #1;
      n_cmp++;
      if (fe_total - fe_start !== 1 || uart_empty !== 1'b1) begin
         n_mis++;
         $display("FAIL frame_err_pulse: cycles=%0d empty=%b expected 1/1",
                  fe_total - fe_start, uart_empty);
      end
      send_frame(8'h55, 1'b1, 1'b0, 1'b1, -1);
      scoreboard_drain("after_ferr");
      n_cmp++;
      if (fe_total - fe_start !== 1) begin
         n_mis++;
         $display("FAIL frame_err_good_frame: cycles=%0d expected 1", fe_total - fe_start);
      end
   endtask

   task automatic test_full_simultaneous();
      for (int i = 0; i < int'(DEPTH); i++)
         send_frame(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'hA4, 1'b1, 1'b1, 1'b0, -1);
      #1;
      n_cmp++;
      if (overrun !== 1'b0 || exp_ovr !== 1'b0) begin
         n_mis++;
         $display("FAIL full_push_pop_overrun: overrun=%b model=%b expected 0", overrun, exp_ovr);
      end
      scoreboard_drain("full_push_pop");
   endtask

   task automatic test_overrun();
      for (int i = 0; i < int'(DEPTH); i++)
         send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, -1);
      #1;
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_mis++;
         $display("FAIL overrun_at_full: overrun=%b expected 0", overrun);
      end
      send_frame(8'h14, 1'b1, 1'b0, 1'b0, -1);
      #1;
      n_cmp++;
      if (overrun !== exp_ovr || exp_ovr !== 1'b1) begin
         n_mis++;
         $display("FAIL overrun_set: overrun=%b expected %b", overrun, exp_ovr);
      end
      scoreboard_drain("overrun");
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_mis++;
         $display("FAIL overrun_sticky: overrun=%b expected 1", overrun);
      end
   endtask

   task automatic test_glitch_and_rst();
      int fe_start;
      fe_start = fe_total;
      @(posedge clk);
      #1 rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      n_cmp++;
      if (fe_total != fe_start || uart_empty !== 1'b1) begin
         n_mis++;
         $display("FAIL glitch_reject: fe_cycles=%0d empty=%b expected 0/1",
                  fe_total - fe_start, uart_empty);
      end
      // Reset lands inside data bit 4 of an all-ones frame.
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 4 * int'(CPB) + int'(CPB) + 4);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (uart_empty !== 1'b1 || uart_in !== 8'h00 || overrun !== 1'b0 || fe_total != fe_start) begin
         n_mis++;
         $display("FAIL rst_mid_frame: empty=%b in=%h ovr=%b fe_cycles=%0d expected 1/00/0/0",
                  uart_empty, uart_in, overrun, fe_total - fe_start);
      end
      send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1);
      scoreboard_drain("after_rst");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_full_simultaneous();
      test_overrun();
      test_glitch_and_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the FIFO depth (16 bytes).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1 frames, LSB first.
REQ-006 SHALL have port uart_rdreq  input  1  pop request from the CPU memory stage.
REQ-007 SHALL have port uart_in  output  8  head byte of the FIFO (show-ahead).
REQ-008 SHALL have port uart_empty  output  1  high when the FIFO holds no bytes.
REQ-009 SHALL have port overrun  output  1  sticky flag: a received byte was dropped.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer, both flops resetting to 1; all receiver logic uses the synchronized value.
REQ-012 SHALL implement receiver states IDLE, START, DATA, STOP.
REQ-013 IDLE: on a 1-to-0 transition of the synchronized line -> START, bit counter loaded with CLKS_PER_BIT/2 - 1 (integer division); a line held low after a frame SHALL NOT start a new frame.
REQ-014 START: counter reaching 0 samples the line; 0 -> DATA with counter CLKS_PER_BIT - 1 and bit index 0; 1 -> IDLE (glitch rejected, no output).
REQ-015 DATA: each counter expiry samples one bit into bit position index (LSB first) and reloads; after bit 7 -> STOP.
REQ-016 STOP: counter expiry samples the stop bit; 1 -> push byte, 0 -> discard byte and pulse frame_err for exactly that cycle; either way -> IDLE.
REQ-017 FIFO SHALL be show-ahead: uart_in equals the oldest stored byte whenever uart_empty is 0; uart_in is don't-care while empty.
REQ-018 A byte pushed at edge N SHALL make uart_empty 0 after edge N (one-cycle latency from stop-bit sample to visibility).
REQ-019 uart_rdreq high at an edge with uart_empty 0 SHALL pop one byte; uart_rdreq while empty SHALL be ignored with no pointer change.
REQ-020 Simultaneous push and pop SHALL both take effect; occupancy unchanged; legal even when full.
REQ-021 Push while full without a same-cycle pop SHALL drop the new byte, keep FIFO contents intact and set overrun; overrun clears only on rst.
REQ-022 Read and write pointers SHALL be DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1); full = MSBs differ and low bits equal, empty = pointers equal.
REQ-023 Bit counter SHALL be 16 bits; no arithmetic overflow for any legal CLKS_PER_BIT.

Reset
REQ-024 rst SHALL force state IDLE, counters and bit index 0, pointers 0, synchronizer flops 1, shift register 0.
REQ-025 During and after rst: uart_empty=1, uart_in=8'h00, overrun=0, frame_err=0.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no push and no frame_err; the first frame after release is received normally once a fresh falling edge occurs.
REQ-027 FIFO storage array need not be reset; uart_in SHALL still read 8'h00 while empty after reset (mux on empty).

Structure
REQ-028 Receiver state encoding and default CLKS_PER_BIT / DEPTH_LOG2 values SHALL live in the shared package uart_pkg.
REQ-029 FIFO SHALL be a sub-module named sync_fifo (parameter DEPTH_LOG2, WIDTH=8) instantiated once; the receiver FSM stays in uart_rx_fifo.

Verification (bench uses CLKS_PER_BIT=8, DEPTH_LOG2=2)
REQ-030 Single frame 8'hA5 on rxd, no rdreq -> uart_empty falls one cycle after stop-bit sample, uart_in=8'hA5; one rdreq pulse -> uart_empty=1.
REQ-031 Frames 8'h01, 8'h02, 8'h03 back-to-back, then three rdreq pulses -> uart_in reads 01, 02, 03 in order, then uart_empty=1.
REQ-032 Five frames 8'h10..8'h14 with no reads -> FIFO holds 10..13, overrun=1 after the fifth stop bit, reads return 10..13 only.
REQ-033 Frame 8'h3C with stop bit driven 0 -> frame_err high exactly one cycle, uart_empty stays 1; following good frame 8'h55 received correctly.
REQ-034 3-cycle low glitch on idle rxd -> no push, no frame_err, state back to IDLE; rst asserted at data bit 4 of frame 8'hFF -> uart_empty=1, next frame 8'h0F received as 8'h0F.
REQ-035 FIFO full (4 bytes) with push and rdreq on the same edge -> occupancy stays 4, overrun stays 0, head advances by one.
